// File: rtl/sw_reg_unit.sv
// ---------------------------------------------------------------------------
// sw_reg_unit
//   Switch-side register endpoint sitting behind the address decoder. Each
//   select pulse runs one register read or write. The unit answers with a
//   one-cycle ack ACK_DELAY cycles later and, for reads, returns the data in
//   that same cycle.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   sel_en     this switch's one-hot select bit from the decoder
//   wr_rd_s    1 = write, 0 = read (qualified by sel_en)
//   addr       register index (qualified by sel_en)
//   wr_data    write data (qualified by sel_en)
//   ack        one-cycle completion pulse (registered)
//   rd_data    read data; zero outside a read-ack cycle (registered)
//   busy       transaction in progress
//   err        pulses with ack when addr is out of range (registered)
//   drop_flag  sticky: a select arrived while busy
// ---------------------------------------------------------------------------
module sw_reg_unit #(
  parameter int                 W_WIDTH   = 8,
  parameter int                 NUM_REGS  = 16,
  parameter int                 ACK_DELAY = 2,
  parameter logic [W_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_en,
  input  logic               wr_rd_s,
  input  logic [W_WIDTH-1:0] addr,
  input  logic [W_WIDTH-1:0] wr_data,
  output logic               ack,
  output logic [W_WIDTH-1:0] rd_data,
  output logic               busy,
  output logic               err,
  output logic               drop_flag
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // One extra bit so the limit itself fits even when NUM_REGS = 2**W_WIDTH.
  localparam logic [W_WIDTH:0] REG_LIMIT = (W_WIDTH + 1)'(NUM_REGS);
  localparam logic [3:0]       CNT_INIT  = (ACK_DELAY >= 2) ? 4'(ACK_DELAY - 2) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [3:0]         cnt;
  logic               lat_wr;
  logic [W_WIDTH-1:0] lat_addr;
  logic [W_WIDTH-1:0] lat_data;
  logic [W_WIDTH-1:0] regs [NUM_REGS];

  logic               accept;
  logic               enter_ack;
  logic               op_wr;
  logic [W_WIDTH-1:0] op_addr;
  logic [W_WIDTH-1:0] op_data;
  logic               op_in_range;
  logic [IDX_W-1:0]   op_idx;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (sel_en) begin
          next_state = (ACK_DELAY == 1) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          next_state = ST_ACK;
        end
      end
      ST_ACK:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy = (state != ST_IDLE);
  end

  // With ACK_DELAY = 1 the ACK state is entered on the same edge that samples
  // the select, before the latches hold anything, so the operation fields come
  // straight from the bus while idle and from the latches otherwise.
  always_comb begin
    accept      = (state == ST_IDLE) && sel_en;
    enter_ack   = (next_state == ST_ACK) && (state != ST_ACK);
    op_wr       = (state == ST_IDLE) ? wr_rd_s : lat_wr;
    op_addr     = (state == ST_IDLE) ? addr    : lat_addr;
    op_data     = (state == ST_IDLE) ? wr_data : lat_data;
    op_in_range = ({1'b0, op_addr} < REG_LIMIT);
    op_idx      = op_addr[IDX_W-1:0];
  end

  // Delay counter: loaded on accept, counts down while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= CNT_INIT;
    end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Transaction fields are captured only when a select is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_wr   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else if (accept) begin
      lat_wr   <= wr_rd_s;
      lat_addr <= addr;
      lat_data <= wr_data;
    end
  end

  // Register file; writes commit on the edge entering ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (enter_ack && op_wr && op_in_range) begin
      regs[op_idx] <= op_data;
    end
  end

  // Completion outputs are flopped so they can be OR-combined downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack     <= 1'b0;
      err     <= 1'b0;
      rd_data <= '0;
    end else begin
      ack     <= enter_ack;
      err     <= enter_ack && !op_in_range;
      rd_data <= (enter_ack && !op_wr && op_in_range) ? regs[op_idx] : '0;
    end
  end

  // Sticky collision flag: any select seen outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_flag <= 1'b0;
    end else if (sel_en && (state != ST_IDLE)) begin
      drop_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sw_reg_unit.sv
// ---------------------------------------------------------------------------
// tb_sw_reg_unit
//   Drives two sw_reg_unit instances (ACK_DELAY = 2 and ACK_DELAY = 1) from a
//   shared bus. A transaction-level model predicts every output each cycle;
//   directed scenarios add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_sw_reg_unit;

  localparam int DLY_A = 2;
  localparam int DLY_B = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel_en = 1'b0;
  logic       wr_rd_s = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wr_data = 8'h00;

  logic       ack_a, busy_a, err_a, drop_a;
  logic [7:0] rd_a;
  logic       ack_b, busy_b, err_b, drop_b;
  logic [7:0] rd_b;

  int vectors = 0;
  int miscompares = 0;

  sw_reg_unit #(.W_WIDTH(8), .NUM_REGS(16), .ACK_DELAY(DLY_A), .RESET_VAL(8'h00)) dut_a (
    .clk(clk), .rst(rst), .sel_en(sel_en), .wr_rd_s(wr_rd_s), .addr(addr),
    .wr_data(wr_data), .ack(ack_a), .rd_data(rd_a), .busy(busy_a), .err(err_a),
    .drop_flag(drop_a)
  );

  sw_reg_unit #(.W_WIDTH(8), .NUM_REGS(16), .ACK_DELAY(DLY_B), .RESET_VAL(8'h00)) dut_b (
    .clk(clk), .rst(rst), .sel_en(sel_en), .wr_rd_s(wr_rd_s), .addr(addr),
    .wr_data(wr_data), .ack(ack_b), .rd_data(rd_b), .busy(busy_b), .err(err_b),
    .drop_flag(drop_b)
  );

  always #5 clk = ~clk;

  // Transaction model: one optional in-flight transaction per instance,
  // identified by the edge number that accepted it.
  int         cyc = 0;
  logic [7:0] mem    [2][16];
  bit         has_txn[2];
  int         acc    [2];
  bit         t_wr   [2];
  logic [7:0] t_addr [2];
  logic [7:0] t_data [2];
  bit         e_ack  [2];
  bit         e_err  [2];
  bit         e_busy [2];
  bit         e_drop [2];
  logic [7:0] e_rd   [2];

  function automatic int delayOf(int i);
    return (i == 0) ? DLY_A : DLY_B;
  endfunction

  function automatic void modelReset(int i);
    for (int r = 0; r < 16; r++) mem[i][r] = 8'h00;
    has_txn[i] = 1'b0;
    acc[i]     = 0;
    e_ack[i]   = 1'b0;
    e_err[i]   = 1'b0;
    e_busy[i]  = 1'b0;
    e_drop[i]  = 1'b0;
    e_rd[i]    = 8'h00;
  endfunction

  function automatic void modelStep(int i);
    int d;
    d = delayOf(i);
    e_ack[i] = 1'b0;
    e_err[i] = 1'b0;
    e_rd[i]  = 8'h00;
    // Busy through the ACK cycle, so the next accept is d+1 edges later.
    if (sel_en) begin
      if (!has_txn[i] || (cyc > acc[i] + d)) begin
        has_txn[i] = 1'b1;
        acc[i]     = cyc;
        t_wr[i]    = wr_rd_s;
        t_addr[i]  = addr;
        t_data[i]  = wr_data;
      end else begin
        e_drop[i] = 1'b1;
      end
    end
    if (has_txn[i] && (cyc == acc[i] + d - 1)) begin
      e_ack[i] = 1'b1;
      if (t_addr[i] >= 8'd16) e_err[i] = 1'b1;
      else if (t_wr[i])       mem[i][t_addr[i][3:0]] = t_data[i];
      else                    e_rd[i] = mem[i][t_addr[i][3:0]];
    end
    e_busy[i] = has_txn[i] && (cyc <= acc[i] + d - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelReset(0);
      modelReset(1);
    end else begin
      cyc++;
      modelStep(0);
      modelStep(1);
    end
  end

  task automatic checkOutput(string name, logic [7:0] actual, logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkInst(string tag, int i, logic ack, logic [7:0] rd, logic busy,
                           logic err, logic drop);
    checkOutput({tag, ".ack"},  {7'd0, ack},  {7'd0, e_ack[i]});
    checkOutput({tag, ".rd"},   rd,           e_rd[i]);
    checkOutput({tag, ".busy"}, {7'd0, busy}, {7'd0, e_busy[i]});
    checkOutput({tag, ".err"},  {7'd0, err},  {7'd0, e_err[i]});
    checkOutput({tag, ".drop"}, {7'd0, drop}, {7'd0, e_drop[i]});
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    checkInst("a", 0, ack_a, rd_a, busy_a, err_a, drop_a);
    checkInst("b", 1, ack_b, rd_b, busy_b, err_b, drop_b);
  end

  // Advances one edge, then drives the bus for the following edge.
  task automatic applyStimulus(logic s, logic w, logic [7:0] a, logic [7:0] d);
    @(posedge clk);
    #2;
    sel_en  = s;
    wr_rd_s = w;
    addr    = a;
    wr_data = d;
  endtask

  task automatic idleStep();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    #1 rst = 1'b1;
    checkOutput("rst.ack_a", {7'd0, ack_a}, 8'h00);
    checkOutput("rst.busy_a", {7'd0, busy_a}, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    checkOutput("rst.drop_a", {7'd0, drop_a}, 8'h00);
    checkOutput("rst.rd_a", rd_a, 8'h00);

    // Write 0xA5 to reg 3.
    applyStimulus(1'b1, 1'b1, 8'h03, 8'hA5);
    idleStep();
    checkOutput("wr.busy_t1", {7'd0, busy_a}, 8'h01);
    checkOutput("wr.ack_t1", {7'd0, ack_a}, 8'h00);
    idleStep();
    checkOutput("wr.busy_t2", {7'd0, busy_a}, 8'h01);
    checkOutput("wr.ack_t2", {7'd0, ack_a}, 8'h01);
    checkOutput("wr.rd_t2", rd_a, 8'h00);
    checkOutput("wr.err_t2", {7'd0, err_a}, 8'h00);
    idleStep();
    checkOutput("wr.ack_t3", {7'd0, ack_a}, 8'h00);
    checkOutput("wr.busy_t3", {7'd0, busy_a}, 8'h00);

    // Read it back.
    applyStimulus(1'b1, 1'b0, 8'h03, 8'h00);
    idleStep();
    checkOutput("rd.rd_t1", rd_a, 8'h00);
    idleStep();
    checkOutput("rd.ack_t2", {7'd0, ack_a}, 8'h01);
    checkOutput("rd.rd_t2", rd_a, 8'hA5);
    idleStep();
    checkOutput("rd.rd_t3", rd_a, 8'h00);

    // Out-of-range write/read, then confirm reg 0 untouched.
    applyStimulus(1'b1, 1'b1, 8'h20, 8'h11);
    idleStep();
    idleStep();
    checkOutput("oor.wr_ack", {7'd0, ack_a}, 8'h01);
    checkOutput("oor.wr_err", {7'd0, err_a}, 8'h01);
    idleStep();
    applyStimulus(1'b1, 1'b0, 8'h20, 8'h00);
    idleStep();
    idleStep();
    checkOutput("oor.rd_ack", {7'd0, ack_a}, 8'h01);
    checkOutput("oor.rd_err", {7'd0, err_a}, 8'h01);
    checkOutput("oor.rd_data", rd_a, 8'h00);
    idleStep();
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    idleStep();
    idleStep();
    checkOutput("alias.ack", {7'd0, ack_a}, 8'h01);
    checkOutput("alias.err", {7'd0, err_a}, 8'h00);
    checkOutput("alias.rd", rd_a, 8'h00);
    idleStep();

    // Collision: second select one cycle after the first.
    applyStimulus(1'b1, 1'b0, 8'h03, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h05, 8'h77);
    checkOutput("col.drop_t1", {7'd0, drop_a}, 8'h00);
    idleStep();
    checkOutput("col.ack_t2", {7'd0, ack_a}, 8'h01);
    checkOutput("col.rd_t2", rd_a, 8'hA5);
    checkOutput("col.drop_t2", {7'd0, drop_a}, 8'h01);
    idleStep();
    checkOutput("col.ack_t3", {7'd0, ack_a}, 8'h00);
    checkOutput("col.drop_t3", {7'd0, drop_a}, 8'h01);
    applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);
    idleStep();
    idleStep();
    checkOutput("col.rd5_ack", {7'd0, ack_a}, 8'h01);
    checkOutput("col.rd5", rd_a, 8'h00);
    checkOutput("col.drop_held", {7'd0, drop_a}, 8'h01);
    idleStep();

    // Reset in the middle of a write.
    applyStimulus(1'b1, 1'b1, 8'h07, 8'h3C);
    idleStep();
    checkOutput("rmid.busy_before", {7'd0, busy_a}, 8'h01);
    rst = 1'b1;
    #1;
    checkOutput("rmid.busy", {7'd0, busy_a}, 8'h00);
    checkOutput("rmid.ack", {7'd0, ack_a}, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    checkOutput("rmid.drop", {7'd0, drop_a}, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h07, 8'h00);
    idleStep();
    idleStep();
    checkOutput("rmid.rd7_ack", {7'd0, ack_a}, 8'h01);
    checkOutput("rmid.rd7", rd_a, 8'h00);
    idleStep();

    // ACK_DELAY = 1 back-to-back on instance b.
    applyStimulus(1'b1, 1'b1, 8'h04, 8'h01);
    idleStep();
    checkOutput("b2b.ack1", {7'd0, ack_b}, 8'h01);
    checkOutput("b2b.rd1", rd_b, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h04, 8'h00);
    checkOutput("b2b.gap", {7'd0, ack_b}, 8'h00);
    idleStep();
    checkOutput("b2b.ack2", {7'd0, ack_b}, 8'h01);
    checkOutput("b2b.rd2", rd_b, 8'h01);
    checkOutput("b2b.drop", {7'd0, drop_b}, 8'h00);
    idleStep();
    checkOutput("b2b.ack_end", {7'd0, ack_b}, 8'h00);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        @(posedge clk);
        #2;
        rst    = 1'b1;
        sel_en = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
      end else begin
        logic       s;
        logic       w;
        logic [7:0] a;
        s = ($urandom_range(0, 9) < 4);
        w = $urandom_range(0, 1) == 1;
        a = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
        applyStimulus(s, w, a, 8'($urandom_range(0, 255)));
      end
    end
    idleStep();
    idleStep();
    idleStep();
    @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
